// File: rtl/dice_pkg.sv
// Shared types and helpers for the dice race turn controller and its settle filter.
package dice_pkg;

    typedef enum logic [2:0] {
        ARMED  = 3'd0,
        DETECT = 3'd1,
        MOVE   = 3'd2,
        CHECK  = 3'd3,
        WIN    = 3'd4
    } turn_state_t;

    typedef logic [1:0] color_t;

    localparam color_t COLOR_NONE  = 2'b00;
    localparam color_t COLOR_RED   = 2'b01;
    localparam color_t COLOR_GREEN = 2'b10;
    localparam color_t COLOR_BLUE  = 2'b11;

    function automatic logic [1:0] color_to_steps(input color_t color);
        logic [1:0] steps;
        case (color)
            COLOR_RED:   steps = 2'd1;
            COLOR_GREEN: steps = 2'd2;
            COLOR_BLUE:  steps = 2'd3;
            default:     steps = 2'd0;
        endcase
        return steps;
    endfunction

endpackage

// File: rtl/roll_settle_filter.sv
// Accepts a dice roll once the same non-zero color is reported SETTLE_COUNT times in a row,
// and abandons the roll after TIMEOUT_FRAMES frames without a settled result.
module roll_settle_filter
    import dice_pkg::*;
#(
    parameter int SETTLE_COUNT   = 3,
    parameter int TIMEOUT_FRAMES = 240
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       frame_start,
    input  logic       result_ready,
    input  color_t     detected_color,
    output logic       accept,
    output logic [1:0] steps,
    output logic       timeout
);

    localparam logic [3:0] SETTLE_N  = 4'(SETTLE_COUNT);
    localparam logic [7:0] TIMEOUT_N = 8'(TIMEOUT_FRAMES);

    color_t     last_color, next_last;
    logic [3:0] match_cnt, next_match;
    logic [7:0] frame_cnt, next_frame;

    // The result is evaluated before the frame count so a settling strobe wins over a timeout.
    always_comb begin
        next_last  = last_color;
        next_match = match_cnt;
        next_frame = frame_cnt;
        if (result_ready) begin
            if (detected_color == COLOR_NONE) begin
                next_last  = COLOR_NONE;
                next_match = 4'd0;
            end else if (detected_color == last_color) begin
                next_match = match_cnt + 4'd1;
            end else begin
                next_last  = detected_color;
                next_match = 4'd1;
            end
        end
        if (frame_start) begin
            next_frame = frame_cnt + 8'd1;
        end
        accept  = enable && result_ready && (detected_color != COLOR_NONE) && (next_match == SETTLE_N);
        timeout = enable && frame_start && (next_frame == TIMEOUT_N) && !accept;
        steps   = color_to_steps(detected_color);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_color <= COLOR_NONE;
            match_cnt  <= 4'd0;
            frame_cnt  <= 8'd0;
        end else if (clear) begin
            last_color <= COLOR_NONE;
            match_cnt  <= 4'd0;
            frame_cnt  <= 8'd0;
        end else if (enable) begin
            last_color <= next_last;
            match_cnt  <= next_match;
            frame_cnt  <= next_frame;
        end
    end

endmodule

// File: rtl/dice_turn_controller.sv
// Turn sequencer for the two-player dice race: arms detection, accepts a settled roll,
// walks the current token one square per frame, detects the winner and alternates turns.
module dice_turn_controller
    import dice_pkg::*;
#(
    parameter int NUM_PLAYERS    = 2,
    parameter int TRACK_LEN      = 20,
    parameter int SETTLE_COUNT   = 3,
    parameter int TIMEOUT_FRAMES = 240
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       roll_btn,
    input  logic [1:0] detected_color,
    input  logic       result_ready,
    output logic       detect_en,
    output logic       cur_player,
    output logic [4:0] pos_p0,
    output logic [4:0] pos_p1,
    output logic       move_valid,
    output logic [1:0] move_steps,
    output logic       timeout_flag,
    output logic       winner_valid,
    output logic       winner_id,
    output logic [2:0] state_dbg
);

    localparam logic [4:0] TRACK = 5'(TRACK_LEN);

    turn_state_t state;
    logic [1:0]  remaining;
    logic        accept, timeout;
    logic [1:0]  steps;
    logic [4:0]  cur_pos, step_pos;

    roll_settle_filter #(
        .SETTLE_COUNT  (SETTLE_COUNT),
        .TIMEOUT_FRAMES(TIMEOUT_FRAMES)
    ) u_filter (
        .clk           (clk),
        .reset         (reset),
        .clear         ((state == ARMED) && roll_btn),
        .enable        (state == DETECT),
        .frame_start   (frame_start),
        .result_ready  (result_ready),
        .detected_color(detected_color),
        .accept        (accept),
        .steps         (steps),
        .timeout       (timeout)
    );

    always_comb begin
        cur_pos  = cur_player ? pos_p1 : pos_p0;
        step_pos = (cur_pos >= TRACK) ? TRACK : cur_pos + 5'd1;
    end

    assign state_dbg = state;

    // move_valid is high only in the first MOVE cycle, so gating on it keeps the entry cycle step-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ARMED;
            detect_en    <= 1'b0;
            cur_player   <= 1'b0;
            pos_p0       <= 5'd0;
            pos_p1       <= 5'd0;
            move_valid   <= 1'b0;
            move_steps   <= 2'd0;
            timeout_flag <= 1'b0;
            winner_valid <= 1'b0;
            winner_id    <= 1'b0;
            remaining    <= 2'd0;
        end else begin
            move_valid   <= 1'b0;
            timeout_flag <= 1'b0;
            case (state)
                ARMED: begin
                    if (roll_btn) begin
                        detect_en <= 1'b1;
                        state     <= DETECT;
                    end
                end
                DETECT: begin
                    if (accept) begin
                        move_steps <= steps;
                        remaining  <= steps;
                        move_valid <= 1'b1;
                        detect_en  <= 1'b0;
                        state      <= MOVE;
                    end else if (timeout) begin
                        timeout_flag <= 1'b1;
                        detect_en    <= 1'b0;
                        state        <= ARMED;
                    end
                end
                MOVE: begin
                    if (frame_start && !move_valid) begin
                        if (cur_player) begin
                            pos_p1 <= step_pos;
                        end else begin
                            pos_p0 <= step_pos;
                        end
                        remaining <= remaining - 2'd1;
                        if (remaining == 2'd1 || step_pos == TRACK) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (cur_pos == TRACK) begin
                        winner_id    <= cur_player;
                        winner_valid <= 1'b1;
                        state        <= WIN;
                    end else begin
                        cur_player <= 1'((int'(cur_player) + 1) % NUM_PLAYERS);
                        state      <= ARMED;
                    end
                end
                WIN: begin
                    if (roll_btn) begin
                        pos_p0       <= 5'd0;
                        pos_p1       <= 5'd0;
                        cur_player   <= 1'b0;
                        winner_valid <= 1'b0;
                        state        <= ARMED;
                    end
                end
                default: state <= ARMED;
            endcase
        end
    end

endmodule

// File: tb/tb_dice_turn_controller.sv
// Self-checking bench for dice_turn_controller: directed game scenarios plus randomized
// play, all compared every cycle against a game-level reference model.
module tb_dice_turn_controller;

    localparam int TRACK = 20;
    localparam int S     = 3;
    localparam int TO    = 240;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_start = 1'b0;
    logic       roll_btn = 1'b0;
    logic [1:0] detected_color = 2'b00;
    logic       result_ready = 1'b0;
    logic       detect_en, cur_player, move_valid, timeout_flag, winner_valid, winner_id;
    logic [4:0] pos_p0, pos_p1;
    logic [1:0] move_steps;
    logic [2:0] state_dbg;

    int tests  = 0;
    int errors = 0;

    // Reference model: game phase (0 armed, 1 detecting, 2 moving, 3 checking, 4 won)
    int m_phase, m_player, m_steps, m_rem, m_winner, m_mv, m_to, m_wv, m_det, m_frames;
    int m_pos[2];
    int hist[$];

    dice_turn_controller #(
        .NUM_PLAYERS(2), .TRACK_LEN(TRACK), .SETTLE_COUNT(S), .TIMEOUT_FRAMES(TO)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .roll_btn(roll_btn),
        .detected_color(detected_color), .result_ready(result_ready),
        .detect_en(detect_en), .cur_player(cur_player), .pos_p0(pos_p0), .pos_p1(pos_p1),
        .move_valid(move_valid), .move_steps(move_steps), .timeout_flag(timeout_flag),
        .winner_valid(winner_valid), .winner_id(winner_id), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_player = 0; m_steps = 0; m_rem = 0; m_winner = 0;
        m_mv = 0; m_to = 0; m_wv = 0; m_det = 0; m_frames = 0;
        m_pos[0] = 0; m_pos[1] = 0;
        hist.delete();
    endtask

    task automatic model_step(input bit roll, input bit fs, input bit rr, input int color);
        int  old_mv = m_mv;
        bit  accepted = 1'b0;
        int  n;
        m_mv = 0;
        m_to = 0;
        case (m_phase)
            0: if (roll) begin
                m_phase = 1; m_det = 1; m_frames = 0; hist.delete();
            end
            1: begin
                if (rr) begin
                    hist.push_back(color);
                    if (hist.size() > 16) void'(hist.pop_front());
                    n = hist.size();
                    if (color != 0 && n >= S) begin
                        accepted = 1'b1;
                        for (int k = 1; k <= S; k++) if (hist[n-k] != color) accepted = 1'b0;
                    end
                end
                if (accepted) begin
                    m_steps = color; m_rem = color; m_mv = 1; m_det = 0; m_phase = 2;
                end else if (fs) begin
                    m_frames++;
                    if (m_frames == TO) begin
                        m_to = 1; m_det = 0; m_phase = 0;
                    end
                end
            end
            2: if (fs && old_mv == 0) begin
                if (m_pos[m_player] < TRACK) m_pos[m_player]++;
                m_rem--;
                if (m_rem == 0 || m_pos[m_player] == TRACK) m_phase = 3;
            end
            3: if (m_pos[m_player] == TRACK) begin
                m_winner = m_player; m_wv = 1; m_phase = 4;
            end else begin
                m_player = 1 - m_player; m_phase = 0;
            end
            4: if (roll) begin
                m_pos[0] = 0; m_pos[1] = 0; m_player = 0; m_wv = 0; m_phase = 0;
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic check_all();
        checkOutput("state_dbg", state_dbg, m_phase);
        checkOutput("detect_en", detect_en, m_det);
        checkOutput("cur_player", cur_player, m_player);
        checkOutput("pos_p0", pos_p0, m_pos[0]);
        checkOutput("pos_p1", pos_p1, m_pos[1]);
        checkOutput("move_valid", move_valid, m_mv);
        checkOutput("move_steps", move_steps, m_steps);
        checkOutput("timeout_flag", timeout_flag, m_to);
        checkOutput("winner_valid", winner_valid, m_wv);
        if (m_wv != 0) checkOutput("winner_id", winner_id, m_winner);
    endtask

    // Called at a falling edge: drive one cycle of inputs, advance the model, check after the edge.
    task automatic applyStimulus(input bit roll, input bit fs, input bit rr, input int color);
        roll_btn       = roll;
        frame_start    = fs;
        result_ready   = rr;
        detected_color = 2'(color);
        model_step(roll, fs, rr, color);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic finish_move();
        int guard = 0;
        while ((m_phase == 2 || m_phase == 3) && guard < 100) begin
            applyStimulus(0, 0, 0, 0);
            if (m_phase == 2) applyStimulus(0, 1, 0, 0);
            guard++;
        end
        checkOutput("turn_done", (state_dbg == 3'd0 || state_dbg == 3'd4), 1);
    endtask

    task automatic run_turn(input int color);
        applyStimulus(1, 0, 0, 0);
        repeat (S) applyStimulus(0, 0, 1, color);
        checkOutput("turn_accept", move_valid, 1);
        finish_move();
    endtask

    int tcount;
    int rcolor;

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        checkOutput("rst_state", state_dbg, 0);
        checkOutput("rst_pos_p0", pos_p0, 0);
        checkOutput("rst_pos_p1", pos_p1, 0);
        checkOutput("rst_flags", {detect_en, move_valid, timeout_flag, winner_valid, winner_id, cur_player}, 0);
        checkOutput("rst_steps", move_steps, 0);
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0);

        // Player 0 rolls green: two steps, then turn passes
        applyStimulus(1, 0, 0, 0);
        checkOutput("t1_detect_en", detect_en, 1);
        applyStimulus(0, 0, 1, 2);
        applyStimulus(0, 0, 1, 2);
        checkOutput("t1_no_early_accept", move_valid, 0);
        applyStimulus(0, 0, 1, 2);
        checkOutput("t1_move_valid", move_valid, 1);
        checkOutput("t1_move_steps", move_steps, 2);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t1_pos_step1", pos_p0, 1);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t1_pos_step2", pos_p0, 2);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t1_next_player", cur_player, 1);
        checkOutput("t1_state_armed", state_dbg, 0);

        // Player 1: a none result breaks a run, then blue settles on the last strobe
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 1, 1);
        checkOutput("t2_run_broken", move_valid, 0);
        applyStimulus(0, 0, 1, 3);
        applyStimulus(0, 0, 1, 3);
        checkOutput("t2_not_yet", move_valid, 0);
        applyStimulus(0, 0, 1, 3);
        checkOutput("t2_accept", move_valid, 1);
        checkOutput("t2_steps", move_steps, 3);
        finish_move();
        checkOutput("t2_pos_p1", pos_p1, 3);

        // Player 0 timeout: no results for TO frames
        tcount = 0;
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < TO; i++) begin
            applyStimulus(0, 1, 0, 0);
            tcount += int'(timeout_flag);
            applyStimulus(0, 0, 0, 0);
            tcount += int'(timeout_flag);
        end
        checkOutput("t3_timeout_pulses", tcount, 1);
        checkOutput("t3_state", state_dbg, 0);
        checkOutput("t3_player", cur_player, 0);
        checkOutput("t3_pos_p0", pos_p0, 2);

        // Drive player 1 to square 19 then overshoot with blue
        for (int i = 0; i < 4; i++) begin
            run_turn(1);
            run_turn(3);
        end
        run_turn(1);
        run_turn(3);
        run_turn(1);
        run_turn(1);
        run_turn(1);
        checkOutput("t4_pos_p1_19", pos_p1, 19);
        applyStimulus(1, 0, 0, 0);
        repeat (S) applyStimulus(0, 0, 1, 3);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t4_saturate", pos_p1, TRACK);
        checkOutput("t4_check", state_dbg, 3);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t4_win", state_dbg, 4);
        checkOutput("t4_winner_id", winner_id, 1);
        applyStimulus(0, 1, 1, 2);
        checkOutput("t4_frozen", pos_p1, TRACK);
        applyStimulus(1, 0, 0, 0);
        checkOutput("t4_new_race", {pos_p0, pos_p1, cur_player, winner_valid}, 0);

        // Settling strobe on the final timeout frame wins
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < TO - 1; i++) begin
            applyStimulus(0, 1, 0, 0);
            applyStimulus(0, 0, 0, 0);
        end
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 1, 1, 1);
        checkOutput("t5_accept", move_valid, 1);
        checkOutput("t5_no_timeout", timeout_flag, 0);
        finish_move();

        // Randomized play with periodic frames
        rcolor = 1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            bit fs, rr, roll;
            fs   = (cyc % 8 == 0);
            rr   = (cyc % 8 >= 2) && (cyc % 8 <= 5) && ($urandom_range(0, 1) == 1);
            roll = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 9) >= 7) rcolor = int'($urandom_range(0, 3));
            applyStimulus(roll, fs, rr, rcolor);
        end

        // Asynchronous reset in the middle of a move; roll requests ignored in DETECT/MOVE
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1, 0, 0, 0);
        repeat (S) applyStimulus(1, 0, 1, 3);
        checkOutput("t6_accept", move_valid, 1);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("t6_stepped", pos_p0, 1);
        checkOutput("t6_in_move", state_dbg, 2);
        #2 reset = 1'b0;
        model_reset();
        #1;
        checkOutput("t6_async_state", state_dbg, 0);
        checkOutput("t6_async_pos", pos_p0, 0);
        checkOutput("t6_async_steps", move_steps, 0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
